// File: rtl/ascii_text_scroller_pkg.sv
// Shared types and constants for the ASCII marquee scroller.
// Used by the top, its interface and the step timer.
package scroller_pkg;

  typedef logic [7:0] char_t;

  localparam char_t ASCII_SPACE = 8'h20;

  typedef enum logic {
    SCROLL,
    DWELL
  } scroll_state_e;

  function automatic int pos_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ascii_text_scroller_if.sv
// Message/control inputs and window/position outputs of the scroller.
// The master drives the controls; the slave is the scroller itself.
interface ascii_text_scroller_if #(
  parameter int MSG_LEN       = 16,
  parameter int DISPLAY_COUNT = 8
);
  localparam int POS_W = scroller_pkg::pos_w(MSG_LEN);

  logic [8*MSG_LEN-1:0]       message;
  logic                       load;
  logic                       run;
  logic                       dir;
  logic [8*DISPLAY_COUNT-1:0] window;
  logic [POS_W-1:0]           pos;
  logic                       step;
  logic                       wrap;

  modport master (
    output message, load, run, dir,
    input  window, pos, step, wrap
  );

  modport slave (
    input  message, load, run, dir,
    output window, pos, step, wrap
  );
endinterface

// File: rtl/ascii_text_scroller_step_timer.sv
// Prescaler counting 0..STEP_CYCLES-1 while enabled.
// The terminal count yields a one-cycle tick and restarts at 0.
module step_timer #(
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);
  import scroller_pkg::*;

  localparam int CW = pos_w(STEP_CYCLES);

  logic [CW-1:0] r_count;

  assign o_tick = i_enable &&
                  (r_count == CW'(STEP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/ascii_text_scroller.sv
// Circular sliding-window marquee over a loaded ASCII message.
// Define SCROLL_PAUSE_EN to dwell PAUSE_STEPS ticks at position 0.
module ascii_text_scroller #(
  parameter int MSG_LEN       = 16,
  parameter int DISPLAY_COUNT = 8,
  parameter int STEP_CYCLES   = 50_000_000,
  parameter int PAUSE_STEPS   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ascii_text_scroller_if.slave  bus
);
  import scroller_pkg::*;

  localparam int POS_W = pos_w(MSG_LEN);
  localparam bit CFG_OK = (MSG_LEN >= 1) &&
                          (STEP_CYCLES >= 2) &&
                          (PAUSE_STEPS >= 1);

  char_t            r_msg [MSG_LEN];
  logic [POS_W-1:0] r_pos;
  logic             r_step;
  logic             r_wrap;
  scroll_state_e    r_state;

  logic [POS_W-1:0] w_pos_nxt;
  logic             w_step_nxt;
  logic             w_wrap_nxt;
  scroll_state_e    w_state_nxt;
  logic             w_tick;
  logic             w_move;
  logic [8*DISPLAY_COUNT-1:0] w_window;

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_enable (bus.run),
    .i_clear  (bus.load),
    .o_tick   (w_tick)
  );

  function automatic logic [POS_W-1:0] win_idx(
    logic [POS_W-1:0] p, int k
  );
    return POS_W'((int'(p) + k) % MSG_LEN);
  endfunction

  assign w_move = CFG_OK && w_tick && !bus.load &&
                  (r_state == SCROLL);

`ifdef SCROLL_PAUSE_EN
  localparam int DW_W = pos_w(PAUSE_STEPS);

  logic [DW_W-1:0] r_dwell;
  logic            w_dwell_last;

  assign w_dwell_last = (r_dwell == DW_W'(PAUSE_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dwell <= '0;
    end else if (bus.load || r_state == SCROLL) begin
      r_dwell <= '0;
    end else if (w_tick) begin
      r_dwell <= w_dwell_last ? '0 : r_dwell + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= SCROLL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef SCROLL_PAUSE_EN
    unique case (1'b1)
      bus.load:                w_state_nxt = DWELL;
      w_move && w_wrap_nxt:    w_state_nxt = DWELL;
      !bus.load && w_tick &&
        r_state == DWELL &&
        w_dwell_last:          w_state_nxt = SCROLL;
      default: ;
    endcase
`endif
  end

  always_comb begin
    w_pos_nxt  = r_pos;
    w_step_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    unique case (1'b1)
      bus.load: w_pos_nxt = '0;
      w_move: begin
        if (bus.dir) begin
          w_pos_nxt = (r_pos == '0) ?
                      POS_W'(MSG_LEN - 1) : r_pos - 1'b1;
        end else begin
          w_pos_nxt = (r_pos == POS_W'(MSG_LEN - 1)) ?
                      '0 : r_pos + 1'b1;
        end
        w_step_nxt = 1'b1;
        w_wrap_nxt = (w_pos_nxt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_msg[i] <= ASCII_SPACE;
      end
      r_pos  <= '0;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (bus.load) begin
        for (int i = 0; i < MSG_LEN; i++) begin
          r_msg[i] <= bus.message[8*(MSG_LEN-i)-1 -: 8];
        end
      end
      r_pos  <= w_pos_nxt;
      r_step <= w_step_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_window = '0;
    for (int k = 0; k < DISPLAY_COUNT; k++) begin
      w_window[8*(DISPLAY_COUNT-k)-1 -: 8] = r_msg[win_idx(r_pos, k)];
    end
  end

  assign bus.window = w_window;
  assign bus.pos    = r_pos;
  assign bus.step   = r_step;
  assign bus.wrap   = r_wrap;
endmodule

// File: tb/tb_ascii_text_scroller.sv
// Directed bench for ascii_text_scroller with a cycle-level reference model.
// Model and literal checks also cover the SCROLL_PAUSE_EN build.
module tb_ascii_text_scroller;
  localparam int ML   = 16;
  localparam int DC   = 8;
  localparam int SC   = 4;
  localparam int PS   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  ascii_text_scroller_if #(.MSG_LEN(ML), .DISPLAY_COUNT(DC)) bus ();

  ascii_text_scroller #(
    .MSG_LEN(ML), .DISPLAY_COUNT(DC),
    .STEP_CYCLES(SC), .PAUSE_STEPS(PS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // reference model: message array, position and prescaler as integers
  byte m_msg [ML];
  int  m_pos, m_cnt, m_dwell;
  bit  m_step, m_wrap;

  always @(posedge clk) begin
    if (!reset_n) begin
      foreach (m_msg[i]) m_msg[i] = 8'h20;
      m_pos = 0; m_cnt = 0; m_dwell = 0;
      m_step = 0; m_wrap = 0;
    end else begin
      m_step = 0; m_wrap = 0;
      if (bus.load) begin
        foreach (m_msg[i]) m_msg[i] = bus.message[8*(ML-1-i) +: 8];
        m_pos = 0; m_cnt = 0;
`ifdef SCROLL_PAUSE_EN
        m_dwell = PS;
`endif
      end else if (bus.run) begin
        if (m_cnt == SC - 1) begin
          m_cnt = 0;
          if (m_dwell > 0) begin
            m_dwell--;
          end else begin
            m_pos  = (m_pos + (bus.dir ? ML - 1 : 1)) % ML;
            m_step = 1;
            m_wrap = (m_pos == 0);
`ifdef SCROLL_PAUSE_EN
            if (m_wrap) m_dwell = PS;
`endif
          end
        end else begin
          m_cnt++;
        end
      end
    end
  end

  function automatic logic [8*DC-1:0] model_window();
    logic [8*DC-1:0] w;
    for (int k = 0; k < DC; k++) w[8*(DC-1-k) +: 8] = m_msg[(m_pos + k) % ML];
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_window", 128'(bus.window), 128'(model_window()));
      chk("model_pos",    128'(bus.pos),    128'(m_pos));
      chk("model_step",   128'(bus.step),   128'(m_step));
      chk("model_wrap",   128'(bus.wrap),   128'(m_wrap));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [127:0] msg_a;
  logic [127:0] msg_b;
  logic [63:0]  w_e0;
  logic [63:0]  w_e1;
  logic [63:0]  w_e15;

  initial begin
    msg_a = "ELO212 UTFSM    ";
    msg_b = "ABCDEFGHIJKLMNOP";
    w_e0  = "ELO212 U";
    w_e1  = "LO212 UT";
    w_e15 = " ELO212 ";
    bus.message = '0;
    bus.load = 0; bus.run = 0; bus.dir = 0;
    reset_n = 0;
    tick(1);
    chk("rst_window", 128'(bus.window), 128'(64'h2020202020202020));
    chk("rst_pos",  128'(bus.pos),  0);
    chk("rst_step", 128'(bus.step), 0);
    chk("rst_wrap", 128'(bus.wrap), 0);
    reset_n = 1;
    chk_en = 1;

    bus.message = msg_a; bus.load = 1;
    tick(1);
    bus.load = 0;
    chk("load_window", 128'(bus.window), 128'(w_e0));
    chk("load_pos", 128'(bus.pos), 0);
    tick(20);
    chk("idle_window", 128'(bus.window), 128'(w_e0));

    bus.run = 1;
`ifndef SCROLL_PAUSE_EN
    tick(3);
    chk("pre_step", 128'(bus.step), 0);
    tick(1);
    chk("step1", 128'(bus.step), 1);
    chk("step1_pos", 128'(bus.pos), 1);
    chk("step1_window", 128'(bus.window), 128'(w_e1));
    tick(60);
    chk("wrap_pos", 128'(bus.pos), 0);
    chk("wrap_pulse", 128'(bus.wrap), 1);
    chk("wrap_window", 128'(bus.window), 128'(w_e0));
    bus.dir = 1;
    tick(4);
    chk("rev_pos", 128'(bus.pos), 15);
    chk("rev_window", 128'(bus.window), 128'(w_e15));
    chk("rev_wrap", 128'(bus.wrap), 0);
    bus.dir = 0;
    tick(27);
    chk("pre_load_pos", 128'(bus.pos), 5);
    bus.load = 1;
    tick(1);
    bus.load = 0;
    chk("coll_pos", 128'(bus.pos), 0);
    chk("coll_step", 128'(bus.step), 0);
    tick(3);
    chk("coll_nostep", 128'(bus.step), 0);
    tick(1);
    chk("coll_next", 128'(bus.pos), 1);
`else
    tick(8);
    chk("dwell_pos", 128'(bus.pos), 0);
    tick(4);
    chk("dwell_exit_pos", 128'(bus.pos), 1);
    chk("dwell_exit_step", 128'(bus.step), 1);
    tick(60);
    chk("dwell_wrap", 128'(bus.wrap), 1);
    tick(8);
    chk("dwell2_pos", 128'(bus.pos), 0);
    tick(4);
    chk("dwell2_exit", 128'(bus.pos), 1);
`endif
    tick(6);
    reset_n = 0; bus.load = 1;
    tick(1);
    chk("mid_rst_window", 128'(bus.window), 128'(64'h2020202020202020));
    chk("mid_rst_pos", 128'(bus.pos), 0);
    chk("mid_rst_step", 128'(bus.step), 0);
    reset_n = 1; bus.load = 0;
    tick(10);

    bus.message = msg_b; bus.load = 1;
    tick(1);
    bus.load = 0; bus.dir = 1;
    tick(14);
    bus.run = 0;
    tick(7);
    bus.run = 1;
    tick(25);
    bus.dir = 0;
    tick(30);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
